mem_axi_sequencer: RTL and testbench

Sequencer between the CPU MEM stage and the MEM-to-AXI bridge. It accepts one load/store request at a time from the pipeline and drives the bridge's single-beat channels in order: AR/R for loads, AW+W/B for stores. Sub-word stores are done as read-modify-write because the bridge always writes with all byte strobes set. The block aligns and sign/zero-extends load data and holds the pipeline stalled until the access completes.

---
 rtl/mem_axi_sequencer_if.sv | 29 ++
 rtl/mem_axi_sequencer.sv | 166 ++++++++++++++++
 tb/tb_mem_axi_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_axi_sequencer_if.sv
// Single-beat AR/R and AW/W/B channels between the MEM-stage sequencer and the AXI bridge.
interface mem_axi_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] m_arwaddr;
    logic              m_awvalid;
    logic              m_awready;
    logic [DATA_W-1:0] m_wdata;
    logic              m_wvalid;
    logic              m_wready;
    logic              m_bvalid;
    logic              m_bready;
    logic              m_arvalid;
    logic              m_arready;
    logic [DATA_W-1:0] m_rdata;
    logic              m_rvalid;
    logic              m_rready;

    modport master (
        output m_arwaddr, m_awvalid, m_wdata, m_wvalid, m_bready, m_arvalid, m_rready,
        input  m_awready, m_wready, m_bvalid, m_arready, m_rdata, m_rvalid
    );

    modport slave (
        input  m_arwaddr, m_awvalid, m_wdata, m_wvalid, m_bready, m_arvalid, m_rready,
        output m_awready, m_wready, m_bvalid, m_arready, m_rdata, m_rvalid
    );
endinterface

// File: rtl/mem_axi_sequencer.sv
// MEM-stage load/store sequencer: one access at a time onto single-beat bus channels,
// sub-word stores as read-modify-write, load data aligned and extended.
module mem_axi_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                we,
    input  logic [1:0]          size,
    input  logic                uns,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata,
    output logic                ack,
    output logic                err,
    output logic                stall,
    mem_axi_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_A, WR_B, DONE} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  addr_q;
    logic [1:0]         size_q;
    logic               uns_q;
    logic               we_q;
    logic [DATA_W-1:0]  sdata_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               ack_q, err_q;
    logic               arvalid_q, awvalid_q, wvalid_q;
    logic               aw_done, w_done;
    logic               misalign;
    logic               ar_hs, aw_ok, w_ok;

    function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] w,
                                                  input logic [1:0] a,
                                                  input logic [1:0] sz,
                                                  input logic u);
        logic [DATA_W-1:0] sb, sh;
        sb = w >> {a, 3'b000};
        sh = w >> {a[1], 4'b0000};
        case (sz)
            2'd0:    extract = {{(DATA_W-8){~u & sb[7]}}, sb[7:0]};
            2'd1:    extract = {{(DATA_W-16){~u & sh[15]}}, sh[15:0]};
            default: extract = w;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                input logic [DATA_W-1:0] d,
                                                input logic [1:0] a,
                                                input logic [1:0] sz);
        logic [DATA_W-1:0] m;
        m = old;
        case (sz)
            2'd0:    m[{a, 3'b000} +: 8]     = d[7:0];
            2'd1:    m[{a[1], 4'b0000} +: 16] = d[15:0];
            default: m = d;
        endcase
        return m;
    endfunction

    always_comb begin
        case (size)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = addr[0];
            2'd2:    misalign = (addr[1:0] != 2'b00);
            default: misalign = 1'b1;
        endcase
    end

    assign ar_hs = arvalid_q & bus.m_arready;
    assign aw_ok = aw_done | (awvalid_q & bus.m_awready);
    assign w_ok  = w_done  | (wvalid_q  & bus.m_wready);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req) begin
                if (misalign)                  state_nxt = DONE;
                else if (we && size == 2'd2)   state_nxt = WR_A;
                else                           state_nxt = RD_A;
            end
            RD_A: if (ar_hs)          state_nxt = RD_D;
            RD_D: if (bus.m_rvalid)   state_nxt = we_q ? WR_A : DONE;
            WR_A: if (aw_ok && w_ok)  state_nxt = WR_B;
            WR_B: if (bus.m_bvalid)   state_nxt = DONE;
            DONE:                     state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.m_arwaddr = {addr_q[ADDR_W-1:2], 2'b00};
        bus.m_arvalid = arvalid_q;
        bus.m_awvalid = awvalid_q;
        bus.m_wvalid  = wvalid_q;
        bus.m_wdata   = wdata_q;
        bus.m_rready  = (state == RD_D);
        bus.m_bready  = (state == WR_B);
        rdata         = rdata_q;
        ack           = ack_q;
        err           = err_q;
        stall         = req & ~ack_q & ~err_q;
    end

    // Valids are registered from the next state so they rise on channel entry and
    // fall the cycle after their own ready; done flags survive only while in WR_A.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            we_q      <= 1'b0;
            sdata_q   <= '0;
            rdata_q   <= '0;
            wdata_q   <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    if (misalign) begin
                        err_q <= 1'b1;
                    end else begin
                        addr_q  <= addr;
                        size_q  <= size;
                        uns_q   <= uns;
                        we_q    <= we;
                        sdata_q <= wdata;
                        if (we && size == 2'd2) wdata_q <= wdata;
                    end
                end
                RD_D: if (bus.m_rvalid) begin
                    if (we_q) begin
                        wdata_q <= merge(bus.m_rdata, sdata_q, addr_q[1:0], size_q);
                    end else begin
                        rdata_q <= extract(bus.m_rdata, addr_q[1:0], size_q, uns_q);
                        ack_q   <= 1'b1;
                    end
                end
                WR_B: if (bus.m_bvalid) ack_q <= 1'b1;
                default: ;
            endcase
            arvalid_q <= (state_nxt == RD_A);
            awvalid_q <= (state_nxt == WR_A) & ~aw_ok;
            wvalid_q  <= (state_nxt == WR_A) & ~w_ok;
            aw_done   <= (state_nxt == WR_A) & aw_ok;
            w_done    <= (state_nxt == WR_A) & w_ok;
        end
    end
endmodule

// File: tb/tb_mem_axi_sequencer.sv
// Self-checking bench for mem_axi_sequencer: latency-configurable bus slave plus a scoreboard of expected results.
module tb_mem_axi_sequencer;
    typedef struct packed {
        logic        st;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'd0;
    logic        uns = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ack, err, stall;

    mem_axi_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_axi_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .we    (we),
        .size  (size),
        .uns   (uns),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ack   (ack),
        .err   (err),
        .stall (stall),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus slave: each ready rises once its valid has been high for *_lat cycles.
    int          ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0;
    logic [31:0] slave_word = '0;
    int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    logic        r_pend, b_pend, aw_seen, w_seen;

    always @(posedge clk) begin
        if (rst) begin
            r_pend = 0; b_pend = 0; aw_seen = 0; w_seen = 0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        end else begin
            if (bus.m_rvalid && bus.m_rready) r_pend = 0;
            if (bus.m_bvalid && bus.m_bready) b_pend = 0;
            if (bus.m_arvalid && bus.m_arready) begin r_pend = 1; r_cnt = 0; end
            if (bus.m_awvalid && bus.m_awready) aw_seen = 1;
            if (bus.m_wvalid && bus.m_wready) w_seen = 1;
            if (aw_seen && w_seen) begin b_pend = 1; b_cnt = 0; aw_seen = 0; w_seen = 0; end
        end
        #1;
        bus.m_rdata = slave_word;
        if (rst) begin
            bus.m_arready = 0; bus.m_rvalid = 0; bus.m_awready = 0;
            bus.m_wready = 0; bus.m_bvalid = 0;
        end else begin
            bus.m_arready = bus.m_arvalid && (ar_cnt >= ar_lat);
            ar_cnt = bus.m_arvalid ? ar_cnt + 1 : 0;
            bus.m_awready = bus.m_awvalid && (aw_cnt >= aw_lat);
            aw_cnt = bus.m_awvalid ? aw_cnt + 1 : 0;
            bus.m_wready = bus.m_wvalid && (w_cnt >= w_lat);
            w_cnt = bus.m_wvalid ? w_cnt + 1 : 0;
            bus.m_rvalid = r_pend && (r_cnt >= r_lat);
            if (r_pend) r_cnt++;
            bus.m_bvalid = b_pend && (b_cnt >= b_lat);
            if (b_pend) b_cnt++;
        end
    end

    int          checks = 0, errors = 0;
    exp_t        sb[$];
    int          base;
    int          ack_rel, err_rel, arv_first, awv_last, wv_last, br_first;
    int          ack_cnt, err_cnt;
    logic        any_valid, err_stall, stall1;
    logic [31:0] ar_addr, w_cap;

    // Drives one request, records per-cycle observations relative to the sampling
    // cycle, and settles each ack against the scoreboard.
    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        int   tail;
        int   rel;
        exp_t e;
        @(posedge clk); #1;
        req = 1; we = w; size = sz; uns = u; addr = a; wdata = d;
        base = cyc;
        ack_rel = -1; err_rel = -1; arv_first = -1; awv_last = -1; wv_last = -1; br_first = -1;
        ack_cnt = 0; err_cnt = 0; any_valid = 0; err_stall = 0; stall1 = 0;
        ar_addr = '0; w_cap = '0;
        tail = -1;
        for (int i = 0; i < 60 && tail != 0; i++) begin
            @(negedge clk);
            rel = cyc - base;
            if (rel == 1) stall1 = stall;
            if (bus.m_arvalid && arv_first < 0) arv_first = rel;
            if (bus.m_arvalid && bus.m_arready) ar_addr = bus.m_arwaddr;
            if (bus.m_awvalid) awv_last = rel;
            if (bus.m_wvalid) wv_last = rel;
            if (bus.m_wvalid && bus.m_wready) w_cap = bus.m_wdata;
            if (bus.m_bready && br_first < 0) br_first = rel;
            if (bus.m_arvalid || bus.m_awvalid || bus.m_wvalid) any_valid = 1;
            if (err) begin
                err_cnt++;
                if (err_rel < 0) err_rel = rel;
                if (stall) err_stall = 1;
            end
            if (ack) begin
                ack_cnt++;
                if (ack_rel < 0) ack_rel = rel;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack addr=%h cycle=%0d", a, rel);
                end else begin
                    e = sb.pop_front();
                    if (e.st && w_cap !== e.data) begin
                        errors++;
                        $display("FAIL store_word addr=%h got=%h exp=%h", a, w_cap, e.data);
                    end else if (!e.st && rdata !== e.data) begin
                        errors++;
                        $display("FAIL load_data addr=%h got=%h exp=%h", a, rdata, e.data);
                    end
                end
            end
            if (tail > 0) begin req = 0; tail--; end
            if (tail < 0 && (ack || err)) tail = 3;
        end
        req = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.m_arvalid, bus.m_awvalid, bus.m_wvalid, bus.m_rready, bus.m_bready, ack, err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=0000000",
                     {bus.m_arvalid, bus.m_awvalid, bus.m_wvalid, bus.m_rready, bus.m_bready, ack, err});
        end
        checks++;
        if (rdata !== 32'h0 || bus.m_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data rdata=%h m_wdata=%h exp=0", rdata, bus.m_wdata);
        end
        rst = 0;
    endtask

    task automatic test_load_word();
        slave_word = 32'hDEADBEEF;
        sb.push_back('{st: 1'b0, data: 32'hDEADBEEF});
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        checks++;
        if (ack_rel !== 3 || arv_first !== 1 || ack_cnt !== 1) begin
            errors++;
            $display("FAIL load_word_timing ack=%0d arv=%0d n=%0d exp=3/1/1", ack_rel, arv_first, ack_cnt);
        end
        checks++;
        if (ar_addr !== 32'h100 || stall1 !== 1'b1) begin
            errors++;
            $display("FAIL load_word_addr addr=%h stall=%b exp=00000100/1", ar_addr, stall1);
        end
    endtask

    task automatic test_load_ext();
        logic [31:0] words [6] = '{32'h80FF0000, 32'h80FF0000, 32'h80FF0000,
                                   32'h80FF0000, 32'h80FF0000, 32'h12348765};
        logic [31:0] addrs [6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h102, 32'h100};
        logic [1:0]  szs   [6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
        logic        unss  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] exps  [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFFFFF,
                                   32'hFFFF80FF, 32'h000080FF, 32'hFFFF8765};
        for (int k = 0; k < 6; k++) begin
            slave_word = words[k];
            sb.push_back('{st: 1'b0, data: exps[k]});
            issue(1'b0, szs[k], unss[k], addrs[k], 32'h0);
            checks++;
            if (ack_rel !== 3) begin
                errors++;
                $display("FAIL load_ext_latency k=%0d got=%0d exp=3", k, ack_rel);
            end
        end
    endtask

    task automatic test_store_subword();
        slave_word = 32'hAABBCCDD;
        sb.push_back('{st: 1'b1, data: 32'h1234CCDD});
        issue(1'b1, 2'd1, 1'b0, 32'h202, 32'h00001234);
        checks++;
        if (ack_rel !== 5 || ack_cnt !== 1 || ar_addr !== 32'h200) begin
            errors++;
            $display("FAIL store_half ack=%0d n=%0d addr=%h exp=5/1/00000200", ack_rel, ack_cnt, ar_addr);
        end
        sb.push_back('{st: 1'b1, data: 32'hAABB55DD});
        issue(1'b1, 2'd0, 1'b0, 32'h201, 32'hFFFFFF55);
        checks++;
        if (ack_rel !== 5 || ack_cnt !== 1) begin
            errors++;
            $display("FAIL store_byte ack=%0d n=%0d exp=5/1", ack_rel, ack_cnt);
        end
    endtask

    task automatic test_store_word();
        sb.push_back('{st: 1'b1, data: 32'hCAFEF00D});
        issue(1'b1, 2'd2, 1'b0, 32'h300, 32'hCAFEF00D);
        checks++;
        if (ack_rel !== 3 || arv_first !== -1) begin
            errors++;
            $display("FAIL store_word_fast ack=%0d arv=%0d exp=3/-1", ack_rel, arv_first);
        end
        w_lat = 3;
        sb.push_back('{st: 1'b1, data: 32'h0BADF00D});
        issue(1'b1, 2'd2, 1'b0, 32'h304, 32'h0BADF00D);
        w_lat = 0;
        checks++;
        if (awv_last !== 1 || wv_last !== 4 || br_first !== 5 || ack_rel !== 6) begin
            errors++;
            $display("FAIL store_word_wdelay aw=%0d w=%0d b=%0d ack=%0d exp=1/4/5/6",
                     awv_last, wv_last, br_first, ack_rel);
        end
    endtask

    task automatic test_err();
        logic [31:0] addrs [3] = '{32'h301, 32'h302, 32'h300};
        logic [1:0]  szs   [3] = '{2'd1, 2'd2, 2'd3};
        for (int k = 0; k < 3; k++) begin
            issue(1'b0, szs[k], 1'b0, addrs[k], 32'h0);
            checks++;
            if (err_rel !== 1 || err_cnt !== 1 || any_valid !== 1'b0 || err_stall !== 1'b0 || ack_cnt !== 0) begin
                errors++;
                $display("FAIL err_case k=%0d err=%0d n=%0d valid=%b stall=%b acks=%0d exp=1/1/0/0/0",
                         k, err_rel, err_cnt, any_valid, err_stall, ack_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic found;
        int   acks;
        r_lat = 20;
        slave_word = 32'h11112222;
        @(posedge clk); #1;
        req = 1; we = 0; size = 2'd2; uns = 0; addr = 32'h400;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (bus.m_rready) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_mid_reach_rd got=0 exp=1");
        end
        rst = 1; req = 0;
        @(negedge clk);
        checks++;
        if ({bus.m_arvalid, bus.m_awvalid, bus.m_wvalid, bus.m_rready, bus.m_bready, ack, err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_mid_ctrl got=%b exp=0000000",
                     {bus.m_arvalid, bus.m_awvalid, bus.m_wvalid, bus.m_rready, bus.m_bready, ack, err});
        end
        rst = 0;
        r_lat = 0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ack || bus.m_rready || bus.m_arvalid) acks++;
        end
        checks++;
        if (acks !== 0) begin
            errors++;
            $display("FAIL reset_mid_quiet got=%0d exp=0", acks);
        end
        slave_word = 32'h33334444;
        sb.push_back('{st: 1'b0, data: 32'h33334444});
        issue(1'b0, 2'd2, 1'b0, 32'h404, 32'h0);
        checks++;
        if (ack_rel !== 3) begin
            errors++;
            $display("FAIL reset_mid_idle ack=%0d exp=3", ack_rel);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h01234567};
        logic [31:0] addrs [3] = '{32'h500, 32'h504, 32'h508};
        exp_t e;
        int   n, last_ack;
        slave_word = words[0];
        sb.push_back('{st: 1'b0, data: words[0]});
        @(posedge clk); #1;
        req = 1; we = 0; size = 2'd2; uns = 0; addr = addrs[0];
        n = 0; last_ack = -1;
        for (int i = 0; i < 40 && n < 3; i++) begin
            @(negedge clk);
            if (ack) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected_ack n=%0d", n);
                end else begin
                    e = sb.pop_front();
                    if (rdata !== e.data) begin
                        errors++;
                        $display("FAIL b2b_data n=%0d got=%h exp=%h", n, rdata, e.data);
                    end
                end
                if (n > 0) begin
                    checks++;
                    if (cyc - last_ack !== 4) begin
                        errors++;
                        $display("FAIL b2b_gap n=%0d got=%0d exp=4", n, cyc - last_ack);
                    end
                end
                last_ack = cyc;
                n++;
                if (n < 3) begin
                    addr = addrs[n];
                    slave_word = words[n];
                    sb.push_back('{st: 1'b0, data: words[n]});
                end else begin
                    req = 0;
                end
            end
        end
        req = 0;
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL b2b_count got=%0d exp=3", n);
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_ext();
        test_store_subword();
        test_store_word();
        test_err();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
